// File: rtl/bin2dec_seq.sv
// Iterative double-dabble binary-to-BCD converter driving an active-low seven-segment bank.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bin2dec_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      V,
    output logic                  Busy,
    output logic                  Done,
    output logic                  OVF,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [7*DIGITS-1:0]   SSD
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    bin_p0;
    logic [4*DIGITS-1:0] scr_p0;
    logic                sovf_p0;

    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scr_n;
    logic [WIDTH-1:0]    bin_n;
    logic                carry;

    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] s);
        logic [4*DIGITS-1:0] a;
        a = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return a;
    endfunction

    // Active-low, bit 0 = segment a ... bit 6 = segment g
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = BLANK;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] render(input logic [4*DIGITS-1:0] b,
                                                   input logic ovf);
        logic [7*DIGITS-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        r = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (b[4*i +: 4] != 4'd0) lead = 1'b0;
`endif
            if (ovf) r[7*i +: 7] = DASH;
`ifdef LEADING_ZERO_BLANK_EN
            else if (lead && i != 0) r[7*i +: 7] = BLANK;
`endif
            else r[7*i +: 7] = glyph(b[4*i +: 4]);
        end
        return r;
    endfunction

    // Add-3 correction happens before the shift; the bit leaving the top digit flags overflow
    always_comb begin
        adj = add3(scr_p0);
        {carry, scr_n, bin_n} = {adj, bin_p0, 1'b0};
    end

    always_ff @(posedge Clock) begin
        if (state == IDLE && Start) begin
            bin_p0  <= V;
            scr_p0  <= '0;
            sovf_p0 <= 1'b0;
        end else if (state == SHIFT) begin
            bin_p0  <= bin_n;
            scr_p0  <= scr_n;
            sovf_p0 <= sovf_p0 | carry;
        end
    end

    // Busy is held through the Done cycle so back-to-back starts land WIDTH+2 edges apart
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            OVF   <= 1'b0;
            BCD   <= '0;
            SSD   <= render('0, 1'b0);
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    Busy <= Start;
                    if (Start) begin
                        state <= SHIFT;
                        cnt   <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIN;
                end
                FIN: begin
                    BCD   <= scr_p0;
                    OVF   <= sovf_p0;
                    SSD   <= render(scr_p0, sovf_p0);
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2dec_seq.sv
// Directed self-checking bench for bin2dec_seq: three instances cover (8,3), (8,2) and a (12,4) sweep.
module tb_bin2dec_seq;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000, DASH = 7'b0111111, BLK = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, busy_a, done_a, ovf_a;
    logic [7:0]  v_a = '0;
    logic [11:0] bcd_a;
    logic [20:0] ssd_a;

    logic        start_b = 1'b0, busy_b, done_b, ovf_b;
    logic [7:0]  v_b = '0;
    logic [7:0]  bcd_b;
    logic [13:0] ssd_b;

    logic        start_c = 1'b0, busy_c, done_c, ovf_c;
    logic [11:0] v_c = '0;
    logic [15:0] bcd_c;
    logic [27:0] ssd_c;

    bin2dec_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
        .Clock(clk), .Reset(rst), .Start(start_a), .V(v_a),
        .Busy(busy_a), .Done(done_a), .OVF(ovf_a), .BCD(bcd_a), .SSD(ssd_a));

    bin2dec_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
        .Clock(clk), .Reset(rst), .Start(start_b), .V(v_b),
        .Busy(busy_b), .Done(done_b), .OVF(ovf_b), .BCD(bcd_b), .SSD(ssd_b));

    bin2dec_seq #(.WIDTH(12), .DIGITS(4)) dut_c (
        .Clock(clk), .Reset(rst), .Start(start_c), .V(v_c),
        .Busy(busy_c), .Done(done_c), .OVF(ovf_c), .BCD(bcd_c), .SSD(ssd_c));

    int n_cmp = 0;
    int n_bad = 0;
    longint cyc = 0;

    logic [11:0] got_bcd;
    logic        got_ovf;
    logic [20:0] got_ssd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [15:0] dec4(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One conversion on dut_a with full timing checks; optional re-pulse of Start at edge 3
    task automatic run_a(input logic [7:0] v, input bit repulse, input string tag);
        int ndone, done_at, last_busy;
        ndone = 0; done_at = -1; last_busy = -1;
        v_a = v;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, "_busy0"}, busy_a, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (done_a) begin
                ndone++;
                done_at = j;
                got_bcd = bcd_a;
                got_ovf = ovf_a;
                got_ssd = ssd_a;
            end
            if (busy_a) last_busy = j;
            if (repulse && j == 2) begin
                start_a = 1'b1;
                v_a = 8'd9;
            end
            if (repulse && j == 3) start_a = 1'b0;
        end
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_done_at"}, done_at, 9);
        check({tag, "_busy_last"}, last_busy, 9);
    endtask

    task automatic run_b(input logic [7:0] v, input string tag);
        bit seen;
        seen = 0;
        v_b = v;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int j = 1; j <= 20 && !seen; j++) begin
            tick();
            if (done_b) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_bcd", bcd_a, 12'h000);
`ifdef LEADING_ZERO_BLANK_EN
        check("rst_ssd", ssd_a, {BLK, BLK, S0});
`else
        check("rst_ssd", ssd_a, {S0, S0, S0});
`endif
        rst = 1'b0;

        run_a(8'd255, 0, "v255");
        check("v255_bcd", got_bcd, 12'h255);
        check("v255_ovf", got_ovf, 1'b0);
        check("v255_ssd", got_ssd, {S2, S5, S5});

        run_a(8'd0, 0, "v0");
        check("v0_bcd", got_bcd, 12'h000);
        check("v0_ovf", got_ovf, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
        check("v0_ssd", got_ssd, {BLK, BLK, S0});
`else
        check("v0_ssd", got_ssd, {S0, S0, S0});
`endif

        run_a(8'd137, 1, "v137");
        check("v137_bcd", got_bcd, 12'h137);
        check("v137_ssd", got_ssd, {S1, S3, S7});
        check("v137_hold", bcd_a, 12'h137);

        // Abort a conversion of 200 with reset at edge 4
        v_a = 8'd200;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", busy_a, 1'b0);
        check("abort_bcd", bcd_a, 12'h000);
        check("abort_ovf", ovf_a, 1'b0);
        begin
            int nd;
            nd = 0;
            for (int j = 0; j < 8; j++) begin
                tick();
                if (done_a) nd++;
            end
            check("abort_nodone", nd, 0);
        end
        rst = 1'b0;
        run_a(8'd200, 0, "v200");
        check("v200_bcd", got_bcd, 12'h200);
        check("v200_ssd", got_ssd, {S2, S0, S0});

        run_b(8'd100, "b100");
        check("b100_ovf", ovf_b, 1'b1);
        check("b100_bcd", bcd_b, 8'h00);
        check("b100_ssd", ssd_b, {DASH, DASH});
        tick();
        run_b(8'd42, "b42");
        check("b42_ovf", ovf_b, 1'b0);
        check("b42_bcd", bcd_b, 8'h42);
        check("b42_ssd", ssd_b, {S4, S2});

        // Back-to-back sweep with Start held high on dut_c
        begin
            longint last_cyc;
            bit seen, abort;
            last_cyc = 0;
            abort = 0;
            v_c = 12'd0;
            start_c = 1'b1;
            for (int i = 0; i < 4096 && !abort; i++) begin
                seen = 0;
                for (int j = 0; j < 20 && !seen; j++) begin
                    tick();
                    if (done_c) seen = 1;
                end
                if (!seen) begin
                    check("sweep_timeout", 1'b0, 1'b1);
                    abort = 1;
                end else begin
                    if (i > 0) check("sweep_spacing", cyc - last_cyc, 14);
                    last_cyc = cyc;
                    check("sweep_bcd", bcd_c, dec4(i));
                    check("sweep_ovf", ovf_c, 1'b0);
                    v_c = 12'(i + 1);
                end
            end
            start_c = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2dec_seq.md
# bin2dec_seq

Sequential, parametrised binary-to-decimal display driver for the DE2 seven-segment bank. It accepts a WIDTH-bit unsigned value on a Start pulse and converts it to DIGITS BCD digits with an iterative shift-and-add-3 (double-dabble) engine. It holds the last completed result on a registered BCD bus and on active-low seven-segment outputs. It replaces the fixed 4-bit, two-digit combinational converter used in the switch-to-HEX labs and can drive HEX0..HEX(DIGITS-1) directly.

## Interface
Parameters:
- WIDTH, 8, bit width of the unsigned binary input (1..32)
- DIGITS, 3, number of decimal digits produced and displayed (1..8)

Ports:
- Clock  input  1  system clock; all state changes on its rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request a conversion of V; sampled only in IDLE
- V  input  WIDTH  unsigned binary value; captured on the accepted Start edge
- Busy  output  1  high while a conversion is in progress (SHIFT or FIN)
- Done  output  1  single-cycle pulse when BCD, SSD and OVF update
- OVF  output  1  last result exceeded 10^DIGITS − 1
- BCD  output  4*DIGITS  result; digit i in BCD[4i+3:4i], digit 0 = units
- SSD  output  7*DIGITS  active-low segments; digit i in SSD[7i+6:7i], bit 7i = segment a … bit 7i+6 = segment g

## Operation
- FSM states: IDLE, SHIFT, FIN.
- IDLE: when Start=1 at a rising edge:
  - Capture V into the shift register.
  - Clear the BCD scratch register and the scratch overflow flag.
  - Load the counter with WIDTH and enter SHIFT.
  - Start=0 keeps the FSM in IDLE.
- SHIFT, each cycle, applied in this order:
  - Add 3 to every scratch digit ≥ 5.
  - Shift the {scratch, binary} concatenation left one bit; the binary MSB enters scratch bit 0.
  - If the bit shifted out of the top scratch digit is 1, set the scratch overflow flag (sticky).
  - Decrement the counter. When it reaches 0, go to FIN.
- FIN, one cycle:
  - Copy scratch to BCD and the scratch overflow flag to OVF, update SSD, pulse Done=1.
  - Return to IDLE.
- Start while Busy=1 is ignored: no queueing, no restart.
- V is sampled only on the accepted Start edge; changes to V during a conversion have no effect.
- Output registers (BCD, SSD, OVF) change only in FIN. Otherwise they hold the last result.
- SSD glyphs are the standard decimal glyphs: 6 has segment a lit, 7 lights a,b,c only, 9 has segment d lit.
- When OVF=1, every digit shows "-": only segment g lit, i.e. 7'b0111111 with bit 6 = g. BCD still carries the truncated low digits.
- Counter width is clog2(WIDTH+1).

## Timing
- Reset values:
  - FSM = IDLE, Busy=0, Done=0, OVF=0, BCD=0.
  - SSD shows "0" on every digit, subject to Configuration.
- Latency: Start accepted at edge k → Busy high from edge k. Done high and results valid for the cycle after edge k+WIDTH+1. Busy low from edge k+WIDTH+2.
- Throughput: one conversion per WIDTH+2 cycles. Start held high continuously re-triggers at edge k+WIDTH+2.
- Done is exactly one cycle wide and coincides with the first cycle of the new BCD/SSD/OVF values.
- Reset asserted mid-conversion aborts immediately: outputs return to reset values and no Done pulse is issued.
- Reset released: the first Start is accepted at the first rising edge at which Reset=0.

## Configuration
- LEADING_ZERO_BLANK_EN, when defined:
  - Each digit i ≥ 1 whose value and all higher digits are 0 is blanked (all seven SSD bits = 1).
  - Digit 0 is never blanked, so the value 0 shows a single "0".
  - Blanking does not apply while OVF=1 (all dashes).
  - BCD is unaffected.
- When not defined: all digits always display, including leading zeros.

## Test plan
- WIDTH=8, DIGITS=3, V=255, Start pulse at edge 0 → Busy=1 for edges 0..9. Done=1 for the single cycle after edge 9. BCD=12'h255, OVF=0, SSD digits show 2,5,5.
- WIDTH=8, DIGITS=3, V=0 → BCD=12'h000, OVF=0. SSD shows "000" without the macro; with LEADING_ZERO_BLANK_EN digits 2 and 1 are 7'h7F and digit 0 shows "0".
- WIDTH=8, DIGITS=2, V=100 → OVF=1, BCD=8'h00, both digits show 7'b0111111. A following conversion of V=42 → OVF=0, BCD=8'h42.
- Start re-pulsed at edge 3 with V changed to 9 during a conversion of V=137 (WIDTH=8, DIGITS=3) → ignored. Result is BCD=12'h137 and only one Done pulse occurs.
- Reset asserted at edge 4 of a conversion of V=200 → immediately Busy=0, BCD=0, OVF=0, no Done pulse. A fresh Start after release with V=200 completes in 10 cycles with BCD=12'h200.
- WIDTH=12, DIGITS=4, sweep V=0..4095 with back-to-back Start held high → every Done spaced exactly 14 cycles apart. BCD matches the decimal reference model, OVF=0 throughout.
